// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, buffers up to two returned
// words for the decoder, and flushes/refetches on redirect while draining stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  stale_cnt;
    logic [1:0]  stale_next;
    logic [1:0]  buf_count;
    logic        head;
    logic        tail;
    logic [31:0] buf_data [2];
    logic [31:0] buf_pc   [2];

    logic        pop;
    logic        rsp;
    logic        req_fire;
    logic        buf_wr;
    logic [2:0]  occupancy;
    logic [31:0] rsp_pc;
    logic [31:0] redirect_target;

    // In FETCH every in-flight request is live and consecutive, so the oldest one
    // (the next to return) sits outstanding words behind fetch_pc.
    always_comb begin
        instr_valid     = (buf_count != 2'd0);
        instr           = buf_data[head];
        instr_pc        = buf_pc[head];
        pop             = instr_valid && instr_ready;
        rsp             = imem_rsp_valid && (outstanding != 2'd0);
        occupancy       = {1'b0, buf_count} + {1'b0, outstanding} - {2'b00, pop};
        imem_req_valid  = (state == FETCH) && !redirect_valid && (occupancy < 3'd2);
        imem_req_addr   = fetch_pc;
        req_fire        = imem_req_valid && imem_req_ready;
        rsp_pc          = fetch_pc - {28'd0, outstanding, 2'b00};
        buf_wr          = (state == FETCH) && rsp && !redirect_valid;
        tail            = head ^ buf_count[0];
        redirect_target = redirect_pc & 32'hFFFF_FFFC;

        state_next = state;
        stale_next = stale_cnt;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    stale_next = outstanding - {1'b0, rsp};
                    if (stale_next != 2'd0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                stale_next = stale_cnt - {1'b0, rsp};
                if (stale_next == 2'd0) begin
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            stale_cnt   <= 2'd0;
            buf_count   <= 2'd0;
            head        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= 32'h0;
                buf_pc[i]   <= 32'h0;
            end
        end else begin
            state       <= state_next;
            stale_cnt   <= stale_next;
            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp};

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (buf_wr) begin
                buf_data[tail] <= imem_rsp_data;
                buf_pc[tail]   <= rsp_pc;
            end

            if (pop) begin
                head <= ~head;
            end

            // A flush wins over any same-cycle write or pop.
            if (redirect_valid) begin
                buf_count <= 2'd0;
            end else begin
                buf_count <= buf_count + {1'b0, buf_wr} - {1'b0, pop};
            end
        end
    end

    ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_wr && (buf_count == 2'd2) && !pop));

endmodule
